// File: rtl/mux_nx1_arb.sv
// Registered N-to-1 arbitrating multiplexer with valid/ready on every input and the output.
// Define MUX_NX1_ARB_RR_EN for round-robin arbitration; otherwise fixed lowest-index priority.
module mux_nx1_arb #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int unsigned CW = SEL_W + 1;

    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic [SEL_W-1:0]  out_sel_q, out_sel_d;

    logic              load;
    logic [SEL_W-1:0]  base;
    logic              gnt_any;
    logic [SEL_W-1:0]  gnt_idx;
    logic [CW-1:0]     cand;
    logic [NUM_IN-1:0] grant;
    logic [WIDTH-1:0]  gnt_data;

    assign load = !out_valid_q || out_ready;

`ifdef MUX_NX1_ARB_RR_EN
    logic [SEL_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (load && gnt_any) begin
            ptr_d = (gnt_idx == SEL_W'(NUM_IN - 1)) ? '0 : gnt_idx + SEL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign base = ptr_q;
`else
    assign base = '0;
`endif

    // Scan upward from base; the extra bit lets base+k exceed NUM_IN before the wrap subtract.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            cand = {1'b0, base} + CW'(k);
            if (cand >= CW'(NUM_IN)) begin
                cand = cand - CW'(NUM_IN);
            end
            if (!gnt_any && in_valid[cand[SEL_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[SEL_W-1:0];
            end
        end
    end

    always_comb begin
        grant    = '0;
        gnt_data = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            grant[i] = gnt_any && (gnt_idx == SEL_W'(i));
            if (grant[i]) begin
                gnt_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Gate with reset_n so no handshake is reported while reset is held.
    assign in_ready = (load && reset_n) ? grant : '0;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (load) begin
            out_valid_d = gnt_any;
            if (gnt_any) begin
                out_data_d = gnt_data;
                out_sel_d  = gnt_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_nx1_arb.sv
// Self-checking bench for mux_nx1_arb: directed scenarios plus randomized traffic against a
// behavioural model of the arbitration rules.
module tb_mux_nx1_arb;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int N3 = 3;

    logic           clk;
    logic           reset_n;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic [1:0]     out_sel;
    logic           out_valid;
    logic           out_ready;

    logic [N3*W-1:0] in_data3;
    logic [N3-1:0]   in_valid3;
    logic [N3-1:0]   in_ready3;
    logic [W-1:0]    out_data3;
    logic [1:0]      out_sel3;
    logic            out_valid3;
    logic            out_ready3;

    int checks = 0;
    int errors = 0;

    mux_nx1_arb #(.WIDTH(W), .NUM_IN(N)) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    mux_nx1_arb #(.WIDTH(W), .NUM_IN(N3)) u_dut3 (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .out_data  (out_data3),
        .out_sel   (out_sel3),
        .out_valid (out_valid3),
        .out_ready (out_ready3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of the 4-input DUT: the held word and the priority pointer.
    logic         m_valid = 1'b0;
    logic [W-1:0] m_data  = '0;
    int           m_sel   = 0;
    int           m_ptr   = 0;

    always @(negedge clk) begin
        int       start, win, idx;
        bit       ld;
        logic [N-1:0] exp_rdy;
        if (!reset_n) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_sel   = 0;
            m_ptr   = 0;
        end
        chk("model_out_valid", 64'(out_valid), 64'(m_valid));
        chk("model_out_data", 64'(out_data), 64'(m_data));
        chk("model_out_sel", 64'(out_sel), 64'(m_sel));
`ifdef MUX_NX1_ARB_RR_EN
        start = m_ptr;
`else
        start = 0;
`endif
        win = -1;
        for (int k = 0; k < N; k++) begin
            idx = (start + k) % N;
            if (win < 0 && in_valid[idx]) win = idx;
        end
        ld      = !m_valid || out_ready;
        exp_rdy = (reset_n && ld && win >= 0) ? N'(1 << win) : '0;
        chk("model_in_ready", 64'(in_ready), 64'(exp_rdy));
        if (reset_n && ld) begin
            if (win >= 0) begin
                m_valid = 1'b1;
                m_data  = in_data[win*W +: W];
                m_sel   = win;
                m_ptr   = (win + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seq[6];
        int pat[4];
        int wrap3[3];
        logic [W-1:0] words[4];
        int stall_sel;
        logic [N-1:0] resume_rdy;

        words[0] = 16'h00A0; words[1] = 16'h00B1; words[2] = 16'h00C2; words[3] = 16'h00D3;
`ifdef MUX_NX1_ARB_RR_EN
        seq   = '{0, 1, 2, 3, 0, 1};
        pat   = '{1, 3, 1, 3};
        wrap3 = '{2, 0, 2};
        stall_sel  = 2;
        resume_rdy = 4'b1000;
`else
        seq   = '{0, 0, 0, 0, 0, 0};
        pat   = '{1, 1, 1, 1};
        wrap3 = '{0, 0, 0};
        stall_sel  = 0;
        resume_rdy = 4'b0001;
`endif

        reset_n    = 1'b0;
        in_valid   = 4'b1111;
        in_data    = {words[3], words[2], words[1], words[0]};
        out_ready  = 1'b1;
        in_valid3  = '0;
        in_data3   = '0;
        out_ready3 = 1'b1;

        // Reset holds everything idle even with all channels requesting.
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_sel", 64'(out_sel), 64'(0));

        step();
        reset_n = 1'b1;
        @(negedge clk);
        chk("first_grant", 64'(in_ready), 64'(4'b0001));

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("seq_sel", 64'(out_sel), 64'(seq[i]));
            chk("seq_data", 64'(out_data), 64'(words[seq[i]]));
        end

        step();
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_valid", 64'(out_valid), 64'(1));
            chk("stall_sel", 64'(out_sel), 64'(stall_sel));
            chk("stall_data", 64'(out_data), 64'(words[stall_sel]));
            chk("stall_in_ready", 64'(in_ready), 64'(0));
        end
        step();
        out_ready = 1'b1;
        @(negedge clk);
        chk("resume_grant", 64'(in_ready), 64'(resume_rdy));

        step();
        in_valid = '0;
        @(negedge clk);
        chk("idle_last_valid", 64'(out_valid), 64'(1));
        chk("idle_last_sel", 64'(out_sel), 64'(N'(resume_rdy) == 4'b1000 ? 3 : 0));
        @(negedge clk);
        chk("idle_valid_drop", 64'(out_valid), 64'(0));
        chk("idle_data_kept", 64'(out_data), 64'(words[out_sel == 2'd3 ? 3 : 0]));
        chk("idle_sel_kept", 64'(out_sel), 64'(N'(resume_rdy) == 4'b1000 ? 3 : 0));

        step();
        in_valid = 4'b1010;
        @(negedge clk);
        chk("pat_first_grant", 64'(in_ready), 64'(4'b0010));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("pat_sel", 64'(out_sel), 64'(pat[i]));
`ifndef MUX_NX1_ARB_RR_EN
            chk("pat_fixed_ready", 64'(in_ready), 64'(4'b0010));
`endif
        end
        step();
        in_valid = '0;

        // Three-input instance: a lone requester streams back to back, then the pointer wraps.
        in_valid3 = 3'b010;
        in_data3[W +: W] = 16'h0100;
        for (int i = 0; i < 5; i++) begin
            step();
            in_data3[W +: W] = W'(16'h0101 + i);
            @(negedge clk);
            chk("sparse_valid", 64'(out_valid3), 64'(1));
            chk("sparse_sel", 64'(out_sel3), 64'(1));
            chk("sparse_data", 64'(out_data3), 64'(16'h0100 + i));
        end
        step();
        in_valid3 = 3'b101;
        in_data3[0 +: W]   = 16'h00AA;
        in_data3[2*W +: W] = 16'h00CC;
        @(negedge clk);
        chk("sparse_last", 64'(out_data3), 64'(16'h0105));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("wrap3_sel", 64'(out_sel3), 64'(wrap3[i]));
            chk("wrap3_data", 64'(out_data3), 64'(wrap3[i] == 2 ? 16'h00CC : 16'h00AA));
        end
        step();
        in_valid3 = '0;

        // Randomized traffic with occasional mid-cycle reset pulses.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            reset_n   = 1'b1;
            in_valid  = N'($urandom);
            in_data   = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 99) == 0) begin
                #2;
                reset_n = 1'b0;
            end
        end
        step();
        reset_n = 1'b1;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
